axil_timer_irq: RTL and testbench
=================================

// Module: axil_timer_irq
// PURPOSE
//  AXI4-Lite slave timer peripheral on a crossbar master port, alongside main memory and the Graphicsystem slave.
//  Counts prescaled clock ticks, compares against a programmable value, and raises a level interrupt into picorv32 irq[IRQ_LINE].
//  Gives firmware a periodic tick for frame pacing without polling the GPU.
// PARAMETERS
//  ADDR_WIDTH  32  AXI-Lite address width (full crossbar address; only addr[4:2] decoded)
//  DATA_WIDTH  32  AXI-Lite data width (fixed 32)
//  STRB_WIDTH  4   DATA_WIDTH/8
// PORTS
//  aclk            in   1           sole clock (CPU/pixel clock domain)
//  aresetn         in   1           asynchronous, active-low reset
//  s_axil_aw*      in/out  std      awaddr[ADDR_WIDTH] awprot[3] awvalid awready
//  s_axil_w*       in/out  std      wdata[32] wstrb[4] wvalid wready
//  s_axil_b*       out/in  std      bresp[2] bvalid bready
//  s_axil_ar*      in/out  std      araddr[ADDR_WIDTH] arprot[3] arvalid arready
//  s_axil_r*       out/in  std      rdata[32] rresp[2] rvalid rready
//  irq             out  1           level interrupt = STATUS.pend & CTRL.ie
// BEHAVIOUR
//  Register map (addr[4:2]):
//   0 CTRL     rw  [0]en [1]reload [2]ie; other bits read 0
//   1 STATUS   w1c [0]pend
//   2 COUNT    rw  32b
//   3 COMPARE  rw  32b
//   4 PRESCALE rw  32b; tick every PRESCALE+1 aclk cycles
//   5-7        unmapped: read 0, write ignored, resp SLVERR (2'b10)
//  Reset: all regs 0, prescale counter 0, awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, irq=0.
//  Write path: AW and W accepted independently, each held in a one-entry latch; ready deasserts once its latch is full.
//   Register update the cycle after both latched; bvalid rises same cycle; latches clear and awready/wready reassert on bvalid&bready.
//   One write outstanding max. wstrb byte-enables apply per byte; awprot ignored.
//  Read path: arready=1 when rvalid=0; on arvalid&arready, rdata/rresp registered, rvalid next cycle; held until rready.
//   Read latency 1 cycle; back-to-back reads every 2 cycles. Reads have no side effects.
//  Timer: when CTRL.en=1, prescale counter increments; at ==PRESCALE it wraps to 0 and issues tick.
//   On tick: if COUNT==COMPARE -> pend<=1; reload=1: COUNT<=0; reload=0: COUNT<=0 and en<=0 (one-shot).
//   Else COUNT<=COUNT+1 (mod 2^32 wrap, no flag).
//   en=0: prescale counter held at 0, COUNT frozen.
//  Simultaneous events:
//   SW write COUNT/CTRL on tick cycle -> SW value wins, tick effect on that reg discarded.
//   W1C pend on same cycle as HW set -> pend stays 1.
//   Write to PRESCALE resets prescale counter to 0.
//  irq combinational from registered pend & ie; no glitch on unrelated writes.
//  Reset mid-transaction: all handshakes abort, valid outputs drop asynchronously, state returns to reset values.
// TESTING
//  1 Reset: aresetn low mid-read -> rvalid=0, irq=0, all regs read 0 after release.
//  2 Write order: W 2 cycles before AW, addr 0x0C data 0x10 -> bvalid 1 cycle after AW, bresp=0, COMPARE reads 0x10.
//  3 Periodic irq: PRESCALE=3, COMPARE=4, CTRL=0x7 -> irq rises 20 cycles after enable; W1C STATUS clears it; recurs every 20 cycles.
//  4 One-shot: CTRL=0x5, COMPARE=2, PRESCALE=0 -> pend set once, CTRL reads 0x4, COUNT stays 0.
//  5 Collision: W1C STATUS on exact HW-set cycle -> pend=1. COUNT write 0x100 on tick cycle -> reads 0x100.
//  6 Strobes/unmapped: wstrb=4'b0010 data 0xAABBCCDD to COMPARE=0 -> 0x0000CC00. Read 0x1C -> rdata=0, rresp=2'b10.
//    rready held low 5 cycles -> rdata stable, no second arready.

Source files
------------

// File: rtl/axil_timer_irq_if.sv
// AXI4-Lite bus bundle between the crossbar master port and the timer peripheral.
interface axil_timer_irq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_timer_irq.sv
// AXI4-Lite timer: prescaled counter compared against COMPARE, raising a level irq
// for periodic firmware frame pacing.
module axil_timer_irq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  axil_timer_irq_if.slave  s_axil,
  output logic             irq
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  r_aw_full;
  logic [2:0]            r_aw_idx;
  logic                  r_w_full;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  r_en;
  logic                  r_reload;
  logic                  r_ie;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_compare;
  logic [DATA_WIDTH-1:0] r_prescale;
  logic [DATA_WIDTH-1:0] r_pscnt;

  logic                  w_wr_fire;
  logic                  w_wr_ctrl;
  logic                  w_wr_status;
  logic                  w_wr_count;
  logic                  w_wr_compare;
  logic                  w_wr_prescale;
  logic                  w_w1c;
  logic                  w_tick;
  logic                  w_match;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [1:0]            w_rd_resp;
  logic                  w_unused_ok;

  function automatic logic [DATA_WIDTH-1:0] f_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign s_axil.awready = ~r_aw_full;
  assign s_axil.wready  = ~r_w_full;
  assign s_axil.bvalid  = r_bvalid;
  assign s_axil.bresp   = r_bresp;
  assign s_axil.arready = ~r_rvalid;
  assign s_axil.rvalid  = r_rvalid;
  assign s_axil.rdata   = r_rdata;
  assign s_axil.rresp   = r_rresp;

  assign w_unused_ok = ^{s_axil.awprot, s_axil.arprot,
                         s_axil.awaddr[ADDR_WIDTH-1:5], s_axil.awaddr[1:0],
                         s_axil.araddr[ADDR_WIDTH-1:5], s_axil.araddr[1:0]};

  // A write commits once both halves are latched; bvalid then blocks further accepts.
  assign w_wr_fire     = r_aw_full & r_w_full & ~r_bvalid;
  assign w_wr_ctrl     = w_wr_fire & (r_aw_idx == 3'd0);
  assign w_wr_status   = w_wr_fire & (r_aw_idx == 3'd1);
  assign w_wr_count    = w_wr_fire & (r_aw_idx == 3'd2);
  assign w_wr_compare  = w_wr_fire & (r_aw_idx == 3'd3);
  assign w_wr_prescale = w_wr_fire & (r_aw_idx == 3'd4);
  assign w_w1c         = w_wr_status & r_wstrb[0] & r_wdata[0];

  assign w_tick  = r_en & (r_pscnt == r_prescale);
  assign w_match = (r_count == r_compare);
  assign irq     = r_pend & r_ie;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (s_axil.awvalid && !r_aw_full) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axil.awaddr[4:2];
      end
      if (s_axil.wvalid && !r_w_full) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axil.wdata;
        r_wstrb  <= s_axil.wstrb;
      end
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (r_aw_idx > 3'd4) ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && s_axil.bready) begin
        r_bvalid  <= 1'b0;
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end
    end
  end

  // Software writes take priority over the tick on the same register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_en       <= 1'b0;
      r_reload   <= 1'b0;
      r_ie       <= 1'b0;
      r_pend     <= 1'b0;
      r_count    <= '0;
      r_compare  <= '0;
      r_prescale <= '0;
      r_pscnt    <= '0;
    end else begin
      if (w_wr_ctrl) begin
        if (r_wstrb[0]) {r_ie, r_reload, r_en} <= r_wdata[2:0];
      end else if (w_tick && w_match && !r_reload) begin
        r_en <= 1'b0;
      end

      r_pend <= (r_pend & ~w_w1c) | (w_tick & w_match);

      if (w_wr_count) begin
        r_count <= f_merge(r_count, r_wdata, r_wstrb);
      end else if (w_tick) begin
        r_count <= w_match ? '0 : r_count + 1'b1;
      end

      if (w_wr_compare)  r_compare  <= f_merge(r_compare, r_wdata, r_wstrb);
      if (w_wr_prescale) r_prescale <= f_merge(r_prescale, r_wdata, r_wstrb);

      if (w_wr_prescale || !r_en || w_tick) begin
        r_pscnt <= '0;
      end else begin
        r_pscnt <= r_pscnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (s_axil.araddr[4:2])
      3'd0:    w_rd_data = {{(DATA_WIDTH-3){1'b0}}, r_ie, r_reload, r_en};
      3'd1:    w_rd_data = {{(DATA_WIDTH-1){1'b0}}, r_pend};
      3'd2:    w_rd_data = r_count;
      3'd3:    w_rd_data = r_compare;
      3'd4:    w_rd_data = r_prescale;
      default: w_rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (r_rvalid) begin
      if (s_axil.rready) r_rvalid <= 1'b0;
    end else if (s_axil.arvalid) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end
  end
endmodule

// File: tb/tb_axil_timer_irq.sv
// Bench for axil_timer_irq: register vector table plus timed sequences for timer,
// write ordering, collisions and reset.
module tb_axil_timer_irq;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0, t1, tdummy;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axil_timer_irq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) bus ();

  axil_timer_irq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axil(bus), .irq(irq)
  );

  typedef struct {
    logic        rd;
    logic [1:0]  resp;
    logic [31:0] data;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic wait_b(input string name);
    int n = 0;
    while (!bus.bvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!bus.bvalid) timeout_fail({name, "_bvalid"});
  endtask

  task automatic pop_b();
    exp_t e;
    if (sb_q.size() == 0) begin
      timeout_fail("scoreboard_empty_b");
    end else begin
      e = sb_q.pop_front();
      chk({e.name, "_bresp"}, {30'd0, bus.bresp}, {30'd0, e.resp});
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp,
                          input string name, output int tb);
    logic aw_acc, w_acc;
    int   n;
    sb_q.push_back('{1'b0, resp, 32'd0, name});
    @(negedge aclk);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      aw_acc = bus.awvalid && bus.awready;
      w_acc  = bus.wvalid && bus.wready;
      @(negedge aclk);
      n++;
      if (aw_acc) bus.awvalid = 1'b0;
      if (w_acc)  bus.wvalid = 1'b0;
    end
    if (bus.awvalid || bus.wvalid) begin
      timeout_fail({name, "_accept"});
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b0;
    end
    wait_b(name);
    tb = cyc;
    pop_b();
    @(negedge aclk);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string name);
    exp_t e;
    logic acc;
    int   n;
    sb_q.push_back('{1'b1, exp_resp, exp_data, name});
    @(negedge aclk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arvalid && n < 50) begin
      acc = bus.arvalid && bus.arready;
      @(negedge aclk);
      n++;
      if (acc) bus.arvalid = 1'b0;
    end
    chk({name, "_latency"}, {31'd0, bus.rvalid}, 32'd1);
    n = 0;
    while (!bus.rvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!bus.rvalid) begin
      timeout_fail({name, "_rvalid"});
      bus.arvalid = 1'b0;
    end
    if (sb_q.size() == 0) begin
      timeout_fail("scoreboard_empty_r");
    end else begin
      e = sb_q.pop_front();
      chk({e.name, "_rdata"}, bus.rdata, e.data);
      chk({e.name, "_rresp"}, {30'd0, bus.rresp}, {30'd0, e.resp});
    end
    @(negedge aclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        2'b00};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h0,        2'b00};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h0,        2'b00};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 32'h10, 32'h0,        4'h0, 32'h0,        2'b00};
    vecs[5]  = '{1'b1, 32'h10, 32'h12345678, 4'hF, 32'h0,        2'b00};
    vecs[6]  = '{1'b0, 32'h10, 32'h0,        4'h0, 32'h12345678, 2'b00};
    vecs[7]  = '{1'b1, 32'h0C, 32'hAABBCCDD, 4'h2, 32'h0,        2'b00};
    vecs[8]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h0000CC00, 2'b00};
    vecs[9]  = '{1'b0, 32'h8000000C, 32'h0,  4'h0, 32'h0000CC00, 2'b00};
    vecs[10] = '{1'b1, 32'h00, 32'hFFFFFFFA, 4'h1, 32'h0,        2'b00};
    vecs[11] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h00000002, 2'b00};
    vecs[12] = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hC, 32'h0,        2'b00};
    vecs[13] = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEAD0000, 2'b00};
    vecs[14] = '{1'b1, 32'h1C, 32'h00000001, 4'hF, 32'h0,        2'b10};
    vecs[15] = '{1'b0, 32'h1C, 32'h0,        4'h0, 32'h0,        2'b10};
    vecs[16] = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h0,        2'b10};
    vecs[17] = '{1'b1, 32'h18, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
    vecs[18] = '{1'b1, 32'h04, 32'h00000001, 4'hF, 32'h0,        2'b00};
    vecs[19] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h0,        2'b00};

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;

    // Reset values
    repeat (3) @(negedge aclk);
    chk("rst_awready", {31'd0, bus.awready}, 32'd1);
    chk("rst_wready",  {31'd0, bus.wready},  32'd1);
    chk("rst_arready", {31'd0, bus.arready}, 32'd1);
    chk("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
    chk("rst_rdata",   bus.rdata,            32'd0);
    chk("rst_irq",     {31'd0, irq},         32'd0);
    aresetn = 1'b1;

    // Reset in the middle of a read that is waiting on rready
    do_write(32'h0C, 32'h55, 4'hF, 2'b00, "pre_rst_cmp", tdummy);
    do_write(32'h00, 32'h6,  4'hF, 2'b00, "pre_rst_ctrl", tdummy);
    @(negedge aclk);
    bus.rready = 1'b0;
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    @(negedge aclk);
    bus.arvalid = 1'b0;
    chk("midrd_rvalid", {31'd0, bus.rvalid}, 32'd1);
    chk("midrd_rdata", bus.rdata, 32'h55);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    chk("midrst_arready", {31'd0, bus.arready}, 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    bus.rready = 1'b1;

    // Register vector table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp,
                 $sformatf("vec%0d_wr", i), tdummy);
      else
        do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, $sformatf("vec%0d_rd", i));
    end
    do_write(32'h00, 32'h0, 4'hF, 2'b00, "clr_ctrl", tdummy);
    do_write(32'h08, 32'h0, 4'hF, 2'b00, "clr_count", tdummy);

    // W arrives two cycles before AW
    sb_q.push_back('{1'b0, 2'b00, 32'd0, "worder"});
    @(negedge aclk);
    bus.wdata = 32'h10; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    bus.wvalid = 1'b0;
    chk("worder_wready_low", {31'd0, bus.wready}, 32'd0);
    @(negedge aclk);
    chk("worder_no_b_yet", {31'd0, bus.bvalid}, 32'd0);
    bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    chk("worder_b_after_aw0", {31'd0, bus.bvalid}, 32'd0);
    @(negedge aclk);
    chk("worder_b_after_aw1", {31'd0, bus.bvalid}, 32'd1);
    wait_b("worder");
    pop_b();
    @(negedge aclk);
    do_read(32'h0C, 32'h10, 2'b00, "worder_cmp");

    // Periodic interrupt
    do_write(32'h10, 32'd3, 4'hF, 2'b00, "per_psc", tdummy);
    do_write(32'h0C, 32'd4, 4'hF, 2'b00, "per_cmp", tdummy);
    do_write(32'h00, 32'h7, 4'hF, 2'b00, "per_ctrl", t0);
    for (int n = 0; n < 100 && !irq; n++) @(negedge aclk);
    chk("per_first_irq_delay", cyc - t0, 32'd20);
    do_write(32'h04, 32'h1, 4'hF, 2'b00, "per_w1c", tdummy);
    chk("per_irq_cleared", {31'd0, irq}, 32'd0);
    for (int n = 0; n < 100 && !irq; n++) @(negedge aclk);
    t1 = cyc;
    chk("per_second_irq_delay", t1 - t0, 32'd40);
    do_write(32'h00, 32'h0, 4'hF, 2'b00, "per_off", tdummy);
    do_write(32'h04, 32'h1, 4'hF, 2'b00, "per_clr", tdummy);
    chk("per_irq_off", {31'd0, irq}, 32'd0);

    // One-shot
    do_write(32'h10, 32'd0, 4'hF, 2'b00, "os_psc", tdummy);
    do_write(32'h0C, 32'd2, 4'hF, 2'b00, "os_cmp", tdummy);
    do_write(32'h08, 32'd0, 4'hF, 2'b00, "os_cnt", tdummy);
    do_write(32'h00, 32'h5, 4'hF, 2'b00, "os_ctrl", tdummy);
    repeat (10) @(negedge aclk);
    do_read(32'h00, 32'h4, 2'b00, "os_ctrl_rd");
    do_read(32'h08, 32'h0, 2'b00, "os_count_rd");
    do_read(32'h04, 32'h1, 2'b00, "os_status_rd");
    chk("os_irq", {31'd0, irq}, 32'd1);
    do_write(32'h04, 32'h1, 4'hF, 2'b00, "os_clr", tdummy);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);
    do_write(32'h00, 32'h0, 4'hF, 2'b00, "os_off", tdummy);

    // W1C landing on the same edge as the hardware set (match at edge 9 after enable)
    do_write(32'h0C, 32'd8, 4'hF, 2'b00, "col_cmp", tdummy);
    do_write(32'h08, 32'd0, 4'hF, 2'b00, "col_cnt", tdummy);
    do_write(32'h00, 32'h3, 4'hF, 2'b00, "col_ctrl", t0);
    sb_q.push_back('{1'b0, 2'b00, 32'd0, "col_w1c"});
    bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    bus.wvalid = 1'b0;
    for (int n = 0; n < 50 && cyc != t0 + 7; n++) @(negedge aclk);
    bus.awaddr = 32'h04; bus.awvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    wait_b("col_w1c");
    pop_b();
    @(negedge aclk);
    do_read(32'h04, 32'h1, 2'b00, "col_pend_kept");
    do_write(32'h00, 32'h0, 4'hF, 2'b00, "col_off", tdummy);
    do_write(32'h04, 32'h1, 4'hF, 2'b00, "col_clr", tdummy);
    do_read(32'h04, 32'h0, 2'b00, "col_pend_clr");

    // COUNT write landing on a tick edge (ticks every 16 cycles)
    do_write(32'h10, 32'd15, 4'hF, 2'b00, "cc_psc", tdummy);
    do_write(32'h0C, 32'hFFFF, 4'hF, 2'b00, "cc_cmp", tdummy);
    do_write(32'h08, 32'd0, 4'hF, 2'b00, "cc_cnt0", tdummy);
    do_write(32'h00, 32'h3, 4'hF, 2'b00, "cc_ctrl", t0);
    sb_q.push_back('{1'b0, 2'b00, 32'd0, "cc_cntw"});
    bus.wdata = 32'h100; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    bus.wvalid = 1'b0;
    for (int n = 0; n < 50 && cyc != t0 + 14; n++) @(negedge aclk);
    bus.awaddr = 32'h08; bus.awvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    wait_b("cc_cntw");
    pop_b();
    do_read(32'h08, 32'h100, 2'b00, "cc_count_rd");
    do_write(32'h00, 32'h0, 4'hF, 2'b00, "cc_off", tdummy);

    // rready held low: rdata stable, no new arready
    @(negedge aclk);
    bus.rready = 1'b0;
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    @(negedge aclk);
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_rvalid", i), {31'd0, bus.rvalid}, 32'd1);
      chk($sformatf("hold%0d_rdata", i), bus.rdata, 32'hFFFF);
      chk($sformatf("hold%0d_arready", i), {31'd0, bus.arready}, 32'd0);
      @(negedge aclk);
    end
    bus.rready = 1'b1;
    @(negedge aclk);
    chk("hold_release_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("hold_release_arready", {31'd0, bus.arready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
